// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, the two cache front ends and the
// main-memory port. The arbiter connects through the master modport; the
// caches and the memory model connect through the slave modport.
//
// Handshake: a cache raises *_req (with write/addr/data) as a level and holds
// it until its *_resp pulse. *_grant marks the cache that owns the memory port.
// mem_req is a one-cycle command strobe; memory completes every command
// (read or write) with exactly one mem_resp pulse. *_resp, resp_data and
// resp_addr are valid only in the cycle the matching *_resp is high.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic                  ic_req;
    logic                  ic_req_write;
    logic [ADDR_WIDTH-1:0] ic_req_addr;
    logic [LINE_WIDTH-1:0] ic_req_data;
    logic                  dc_req;
    logic                  dc_req_write;
    logic [ADDR_WIDTH-1:0] dc_req_addr;
    logic [LINE_WIDTH-1:0] dc_req_data;
    logic                  ic_grant;
    logic                  dc_grant;
    logic                  ic_resp;
    logic                  dc_resp;
    logic [LINE_WIDTH-1:0] resp_data;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic                  mem_req;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [LINE_WIDTH-1:0] mem_req_data;
    logic                  mem_resp;
    logic [LINE_WIDTH-1:0] mem_resp_data;
    logic [ADDR_WIDTH-1:0] mem_resp_addr;

    modport master (
        input  ic_req, ic_req_write, ic_req_addr, ic_req_data,
        input  dc_req, dc_req_write, dc_req_addr, dc_req_data,
        input  mem_resp, mem_resp_data, mem_resp_addr,
        output ic_grant, dc_grant, ic_resp, dc_resp, resp_data, resp_addr,
        output mem_req, mem_req_write, mem_req_addr, mem_req_data
    );

    modport slave (
        output ic_req, ic_req_write, ic_req_addr, ic_req_data,
        output dc_req, dc_req_write, dc_req_addr, dc_req_data,
        output mem_resp, mem_resp_data, mem_resp_addr,
        input  ic_grant, dc_grant, ic_resp, dc_resp, resp_data, resp_addr,
        input  mem_req, mem_req_write, mem_req_addr, mem_req_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and
// the D-cache. One transaction at a time: arbitrate in IDLE, issue a one-cycle
// command in ISSUE, hold the owner's grant in WAIT until memory responds.
// dbg_state exposes the FSM encoding (0 IDLE, 1 ISSUE, 2 WAIT).
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus,
    output logic [1:0]    dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Owner encoding: 0 = I-cache, 1 = D-cache.
    state_t                state;
    state_t                state_n;
    logic                  owner;
    logic                  last_owner;
    logic                  take;
    logic                  win;
    logic                  lat_write;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [LINE_WIDTH-1:0] lat_data;
    logic                  busy;
    logic                  resp_fire;

    // Next state and arbitration; a tie goes to whoever did not win last.
    always_comb begin
        state_n = state;
        take    = 1'b0;
        win     = last_owner;
        case (state)
            IDLE: begin
                if (bus.ic_req && bus.dc_req) begin
                    win = ~last_owner;
                end else begin
                    win = bus.dc_req;
                end
                if (bus.ic_req || bus.dc_req) begin
                    take    = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: state_n = bus.mem_resp ? IDLE : WAIT;
            WAIT:  state_n = bus.mem_resp ? IDLE : WAIT;
            default: state_n = IDLE;
        endcase
    end

    // State register plus the command latch, captured only on the IDLE cycle
    // so later requester changes cannot disturb an issued command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                owner      <= win;
                last_owner <= win;
                lat_write  <= win ? bus.dc_req_write : bus.ic_req_write;
                lat_addr   <= win ? bus.dc_req_addr  : bus.ic_req_addr;
                lat_data   <= win ? bus.dc_req_data  : bus.ic_req_data;
            end
        end
    end

    // Grants and memory command come from registered state only; the response
    // path is combinational from mem_resp and is suppressed while in reset so
    // an in-flight completion is dropped.
    always_comb begin
        busy              = (state != IDLE);
        resp_fire         = busy && bus.mem_resp && !reset;
        bus.ic_grant      = busy && !owner;
        bus.dc_grant      = busy && owner;
        bus.mem_req       = (state == ISSUE);
        bus.mem_req_write = lat_write;
        bus.mem_req_addr  = lat_addr;
        bus.mem_req_data  = lat_data;
        bus.ic_resp       = resp_fire && !owner;
        bus.dc_resp       = resp_fire && owner;
        bus.resp_data     = resp_fire ? bus.mem_resp_data : '0;
        bus.resp_addr     = resp_fire ? bus.mem_resp_addr : '0;
        dbg_state         = state;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change 1 time unit after each rising
// edge; outputs are checked 1 unit later, well away from the clock edge.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_pass;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic idle_inputs();
        bus.ic_req = 1'b0; bus.ic_req_write = 1'b0; bus.ic_req_addr = '0; bus.ic_req_data = '0;
        bus.dc_req = 1'b0; bus.dc_req_write = 1'b0; bus.dc_req_addr = '0; bus.dc_req_data = '0;
        bus.mem_resp = 1'b0; bus.mem_resp_data = '0; bus.mem_resp_addr = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic mem_respond(input logic [AW-1:0] addr, input logic [LW-1:0] data);
        bus.mem_resp      = 1'b1;
        bus.mem_resp_addr = addr;
        bus.mem_resp_data = data;
    endtask

    logic [LW-1:0] d_line;
    logic [LW-1:0] l_line;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        d_line   = {4{32'hCAFE_0001}};
        l_line   = {4{32'h1234_5678}};
        idle_inputs();

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        #1;
        check("rst_state", LW'(dbg_state), LW'(S_IDLE));
        check("rst_ic_grant", LW'(bus.ic_grant), '0);
        check("rst_dc_grant", LW'(bus.dc_grant), '0);
        check("rst_mem_req", LW'(bus.mem_req), '0);
        check("rst_mem_addr", LW'(bus.mem_req_addr), '0);
        check("rst_mem_data", bus.mem_req_data, '0);
        reset = 1'b0;

        // Single I-cache read of 0x100, response at cycle 4
        bus.ic_req = 1'b1; bus.ic_req_addr = 32'h100;
        #1 check("t1_c0_grant", LW'(bus.ic_grant), '0);
        tick(); #1;                                          // cycle 1
        check("t1_c1_ic_grant", LW'(bus.ic_grant), 1);
        check("t1_c1_dc_grant", LW'(bus.dc_grant), 0);
        check("t1_c1_mem_req", LW'(bus.mem_req), 1);
        check("t1_c1_addr", LW'(bus.mem_req_addr), LW'(32'h100));
        check("t1_c1_write", LW'(bus.mem_req_write), 0);
        tick(); #1;                                          // cycle 2
        check("t1_c2_mem_req", LW'(bus.mem_req), 0);
        check("t1_c2_state", LW'(dbg_state), LW'(S_WAIT));
        tick();                                              // cycle 3
        tick();                                              // cycle 4
        mem_respond(32'h100, d_line);
        #1;
        check("t1_c4_ic_resp", LW'(bus.ic_resp), 1);
        check("t1_c4_dc_resp", LW'(bus.dc_resp), 0);
        check("t1_c4_data", bus.resp_data, d_line);
        check("t1_c4_addr", LW'(bus.resp_addr), LW'(32'h100));
        check("t1_c4_grant", LW'(bus.ic_grant), 1);
        tick();                                              // cycle 5
        idle_inputs();
        #1;
        check("t1_c5_grant", LW'(bus.ic_grant), 0);
        check("t1_c5_resp", LW'(bus.ic_resp), 0);

        // Tie right after reset: D-cache first, then I-cache, then D again
        do_reset();
        bus.ic_req = 1'b1; bus.ic_req_addr = 32'h140;        // cycle 0
        bus.dc_req = 1'b1; bus.dc_req_addr = 32'h180;
        tick(); #1;                                          // cycle 1
        check("t2_c1_dc_grant", LW'(bus.dc_grant), 1);
        check("t2_c1_ic_grant", LW'(bus.ic_grant), 0);
        check("t2_c1_addr", LW'(bus.mem_req_addr), LW'(32'h180));
        tick();                                              // cycle 2: response
        mem_respond(32'h180, d_line);
        #1;
        check("t2_c2_dc_resp", LW'(bus.dc_resp), 1);
        check("t2_c2_ic_resp", LW'(bus.ic_resp), 0);
        tick();                                              // cycle 3: IDLE, new tie
        bus.mem_resp = 1'b0;
        bus.dc_req_addr = 32'h1C0;
        #1;
        check("t2_c3_state", LW'(dbg_state), LW'(S_IDLE));
        check("t2_c3_grants", LW'({bus.ic_grant, bus.dc_grant}), 0);
        tick(); #1;                                          // cycle 4 = resp+2
        check("t2_c4_ic_grant", LW'(bus.ic_grant), 1);
        check("t2_c4_dc_grant", LW'(bus.dc_grant), 0);
        check("t2_c4_mem_req", LW'(bus.mem_req), 1);
        check("t2_c4_addr", LW'(bus.mem_req_addr), LW'(32'h140));
        mem_respond(32'h140, l_line);                        // response in ISSUE
        #1;
        check("t2_c4_ic_resp", LW'(bus.ic_resp), 1);
        check("t2_c4_data", bus.resp_data, l_line);
        tick();                                              // cycle 5
        bus.mem_resp = 1'b0;
        bus.ic_req = 1'b0;
        #1;
        check("t2_c5_state", LW'(dbg_state), LW'(S_IDLE));
        tick(); #1;                                          // cycle 6
        check("t2_c6_dc_grant", LW'(bus.dc_grant), 1);
        check("t2_c6_addr", LW'(bus.mem_req_addr), LW'(32'h1C0));
        mem_respond(32'h1C0, d_line);
        tick();                                              // cycle 7
        idle_inputs();

        // D-cache eviction write to 0x240, address changes while waiting
        tick();
        bus.dc_req = 1'b1; bus.dc_req_write = 1'b1;
        bus.dc_req_addr = 32'h240; bus.dc_req_data = l_line;
        tick(); #1;                                          // ISSUE
        check("t3_issue_mem_req", LW'(bus.mem_req), 1);
        check("t3_issue_write", LW'(bus.mem_req_write), 1);
        check("t3_issue_data", bus.mem_req_data, l_line);
        check("t3_issue_ic_grant", LW'(bus.ic_grant), 0);
        tick();                                              // WAIT
        bus.dc_req_addr  = 32'h300;
        bus.dc_req_data  = d_line;
        bus.dc_req_write = 1'b0;
        #1;
        check("t3_wait_mem_req", LW'(bus.mem_req), 0);
        check("t3_wait_ic_grant", LW'(bus.ic_grant), 0);
        tick(); #1;
        check("t3_hold_addr", LW'(bus.mem_req_addr), LW'(32'h240));
        check("t3_hold_write", LW'(bus.mem_req_write), 1);
        check("t3_hold_data", bus.mem_req_data, l_line);
        mem_respond(32'h240, '0);
        #1;
        check("t3_dc_resp", LW'(bus.dc_resp), 1);
        check("t3_ic_resp", LW'(bus.ic_resp), 0);
        check("t3_resp_ic_grant", LW'(bus.ic_grant), 0);
        check("t3_resp_addr", LW'(bus.resp_addr), LW'(32'h240));
        tick();
        idle_inputs();
        #1;
        check("t3_after_grant", LW'(bus.dc_grant), 0);

        // Spurious mem_resp in IDLE
        tick();
        mem_respond(32'h999, d_line);
        #1;
        check("t4_ic_resp", LW'(bus.ic_resp), 0);
        check("t4_dc_resp", LW'(bus.dc_resp), 0);
        tick(); #1;
        check("t4_state", LW'(dbg_state), LW'(S_IDLE));
        check("t4_mem_req", LW'(bus.mem_req), 0);
        idle_inputs();

        // Reset while waiting; the late response is ignored
        tick();
        bus.ic_req = 1'b1; bus.ic_req_addr = 32'h500;
        tick();                                              // ISSUE
        tick();                                              // WAIT
        #1 check("t5_wait_state", LW'(dbg_state), LW'(S_WAIT));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.ic_req = 1'b0;
        mem_respond(32'h500, d_line);
        #1;
        check("t5_state", LW'(dbg_state), LW'(S_IDLE));
        check("t5_grants", LW'({bus.ic_grant, bus.dc_grant}), 0);
        check("t5_late_resp", LW'({bus.ic_resp, bus.dc_resp}), 0);
        check("t5_addr_zero", LW'(bus.mem_req_addr), '0);
        tick(); #1;
        check("t5_still_idle", LW'(dbg_state), LW'(S_IDLE));
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
